maze_move_ctrl: RTL
===================

# maze_move_ctrl

Move executor downstream of the Q-learning/exploit stage. It accepts the next state that stage requests, checks the move against the 6×6 maze geometry and the blocked-cell list, and drives a timed one-cell move. It then reports the new position as `maze_state` and pulses `move_complete`, closing the exploit loop: `next_state`/`timer_start` in, `maze_state`/`move_complete` out.

## Interface
Parameters:
- `MOVE_CYCLES`, default 50_000_000: clock cycles the motor is enabled per one-cell move; must be ≥1.
- `NUM_BLOCKED`, default 16: entries in the blocked-cell list.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_load`  in  1  one-cycle pulse; loads `start_state` as current position and aborts any move.
- `start_state`  in  6  start cell, 0..35.
- `blocked`  in  6×NUM_BLOCKED  blocked cells; value 63 marks an unused entry.
- `timer_start`  in  1  move request strobe; `next_state` valid in same cycle.
- `next_state`  in  6  requested destination cell.
- `maze_state`  out  6  current cell, registered.
- `move_complete`  out  1  one-cycle pulse when a request finishes.
- `motor_en`  out  1  high while a move is being timed.
- `dir`  out  2  0 up (−6), 1 right (+1), 2 down (+6), 3 left (−1); valid while `motor_en`=1.
- `busy`  out  1  high in any state other than IDLE and FAULT.
- `fault`  out  1  sticky illegal-request flag.

## Operation
- Cell index = row×6 + col; rows and cols are 0..5. Cells 36..63 are illegal destinations.
- FSM states: IDLE, CHECK, MOVING, DONE, FAULT.
- **IDLE.** `timer_start`=1: register `next_state` into `target_q`, then go to CHECK. `timer_start` outside IDLE is ignored, and no request is queued.
- **CHECK.** Evaluate the registered request:
  - `target_q` = `maze_state`: go to DONE, no motor motion.
  - Legal move: go to MOVING. Legal means `target_q`≤35, the cell is orthogonally adjacent, there is no row wrap (col 5 → col 0 is not "right"), and `target_q` matches no `blocked` entry.
  - Otherwise: go to FAULT.
- **MOVING.**
  - `motor_en`=1 and `dir` held constant.
  - Down-counter loaded with MOVE_CYCLES−1 on entry; decrements each cycle.
  - At count 0, go to DONE.
- **DONE.** `maze_state` ← `target_q`, `move_complete`=1 for exactly one cycle, then IDLE.
- **FAULT.**
  - `fault`=1 and `maze_state` unchanged; no `move_complete` pulse.
  - Stays in FAULT until `start_load` or `rst`.
- **`start_load`, any state.** Next cycle: `maze_state` ← `start_state`, `fault` ← 0, counter cleared, `motor_en` ← 0, state ← IDLE.
- `start_load` and `timer_start` in the same cycle: `start_load` wins; the request is dropped.
- `start_state` > 35 on `start_load`: load the value anyway and set `fault`=1 (state FAULT).
- Counter width is $clog2(MOVE_CYCLES+1); it must not wrap.

## Timing
- Reset values: `maze_state`=0, `move_complete`=0, `motor_en`=0, `dir`=0, `busy`=0, `fault`=0, FSM=IDLE, `target_q`=0, counter=0.
- Request sampled at edge t:
  - CHECK during cycle t+1.
  - `motor_en`=1 during cycles t+2 .. t+1+MOVE_CYCLES.
  - `move_complete`=1 and the new `maze_state` visible during cycle t+2+MOVE_CYCLES.
  - IDLE at t+3+MOVE_CYCLES.
- Zero-move request: `move_complete` during cycle t+2.
- Illegal request: `fault`=1 from cycle t+2.
- All outputs come straight from registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `maze_pkg`:
  - `GRID_W`=6, `NUM_CELLS`=36, `NO_BLOCK`=6'd63.
  - `cell_t` (6-bit).
  - `dir_t` enum.
  - FSM state enum.
- Sub-module `maze_adjacency`: combinational; inputs `cur`, `nxt`; outputs `adjacent`, `dir`. Also reused by the exploit stage's checks.

## Test plan
- Reset, then `start_load` with `start_state`=7, then `timer_start` with `next_state`=8 (MOVE_CYCLES=4): `motor_en` high for 4 cycles with `dir`=1, then `move_complete` pulse and `maze_state`=8.
- From 11 (col 5) request 12: `fault`=1 at t+2, `maze_state` stays 11, no `move_complete`; a later `start_load` with 0 clears `fault`.
- `blocked[3]`=14, from 8 request 14 → FAULT. With `blocked` all 63, the same request moves with `dir`=2.
- Request 20 while `maze_state`=20: `move_complete` at t+2, `motor_en` never asserted.
- Mid-MOVING `start_load` with 30: `motor_en` drops next cycle, `maze_state`=30, no `move_complete`. A `timer_start` while busy is ignored.
- Async `rst` asserted mid-move between clock edges: all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module  : maze_pkg
// Brief   : Shared maze geometry constants, cell/direction/FSM types.
// Revision: 1.0
// ============================================================================
package maze_pkg;

    localparam int GRID_W    = 6;
    localparam int NUM_CELLS = 36;

    typedef logic [5:0] cell_t;

    localparam cell_t NO_BLOCK = 6'd63;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_MOVING = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    function automatic logic cell_valid(input cell_t c);
        return c < cell_t'(NUM_CELLS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_adjacency.sv
`default_nettype none
// ============================================================================
// Module  : maze_adjacency
// Brief   : Combinational orthogonal-neighbour test between two maze cells.
// Revision: 1.0
// ============================================================================
module maze_adjacency
    import maze_pkg::*;
(
    input  cell_t cur,
    input  cell_t nxt,
    output logic  adjacent,
    output dir_t  dir
);

    cell_t w_cur_row;
    cell_t w_cur_col;
    cell_t w_nxt_row;
    cell_t w_nxt_col;

    always_comb begin
        w_cur_row = cur / cell_t'(GRID_W);
        w_cur_col = cur % cell_t'(GRID_W);
        w_nxt_row = nxt / cell_t'(GRID_W);
        w_nxt_col = nxt % cell_t'(GRID_W);
    end

    // Row/column comparison rather than index arithmetic keeps col 5 -> col 0
    // from looking like a step to the right.
    always_comb begin
        adjacent = 1'b0;
        dir      = DIR_UP;
        if (cell_valid(cur) && cell_valid(nxt)) begin
            if (w_nxt_col == w_cur_col) begin
                if (w_nxt_row + 6'd1 == w_cur_row) begin
                    adjacent = 1'b1;
                    dir      = DIR_UP;
                end else if (w_nxt_row == w_cur_row + 6'd1) begin
                    adjacent = 1'b1;
                    dir      = DIR_DOWN;
                end
            end else if (w_nxt_row == w_cur_row) begin
                if (w_nxt_col == w_cur_col + 6'd1) begin
                    adjacent = 1'b1;
                    dir      = DIR_RIGHT;
                end else if (w_nxt_col + 6'd1 == w_cur_col) begin
                    adjacent = 1'b1;
                    dir      = DIR_LEFT;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : maze_move_ctrl
// Brief   : Validates a requested one-cell move and times the motor for it.
// Revision: 1.0
// ============================================================================
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int MOVE_CYCLES = 50_000_000,
    parameter int NUM_BLOCKED = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_load,
    input  logic [5:0]                 start_state,
    input  logic [6*NUM_BLOCKED-1:0]   blocked,
    input  logic                       timer_start,
    input  logic [5:0]                 next_state,
    output logic [5:0]                 maze_state,
    output logic                       move_complete,
    output logic                       motor_en,
    output logic [1:0]                 dir,
    output logic                       busy,
    output logic                       fault
);

    localparam int               CNT_W  = $clog2(MOVE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_load = CNT_W'(MOVE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    cell_t            r_target;
    logic [CNT_W-1:0] r_count;
    logic             w_adjacent;
    dir_t             w_adj_dir;
    logic             w_blocked_hit;
    logic             w_legal;

    maze_adjacency u_adj (
        .cur      (maze_state),
        .nxt      (r_target),
        .adjacent (w_adjacent),
        .dir      (w_adj_dir)
    );

    always_comb begin
        w_blocked_hit = 1'b0;
        for (int i = 0; i < NUM_BLOCKED; i++) begin
            if (blocked[i*$bits(cell_t) +: $bits(cell_t)] == r_target) begin
                w_blocked_hit = 1'b1;
            end
        end
    end

    assign w_legal = w_adjacent && !w_blocked_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (timer_start) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_target == maze_state) begin
                    w_state_nxt = S_DONE;
                end else if (w_legal) begin
                    w_state_nxt = S_MOVING;
                end else begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_MOVING: begin
                if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
        // A load overrides everything, including a same-cycle request.
        if (start_load) begin
            w_state_nxt = cell_valid(start_state) ? S_IDLE : S_FAULT;
        end
    end

    // Status outputs are registered copies of the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maze_state    <= '0;
            move_complete <= 1'b0;
            motor_en      <= 1'b0;
            dir           <= DIR_UP;
            busy          <= 1'b0;
            fault         <= 1'b0;
            r_target      <= '0;
            r_count       <= '0;
        end else begin
            move_complete <= (w_state_nxt == S_DONE);
            motor_en      <= (w_state_nxt == S_MOVING);
            fault         <= (w_state_nxt == S_FAULT);
            busy          <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FAULT);

            if (r_state == S_IDLE && timer_start && !start_load) begin
                r_target <= next_state;
            end

            if (start_load) begin
                maze_state <= start_state;
                r_count    <= '0;
            end else begin
                if (r_state != S_DONE && w_state_nxt == S_DONE) begin
                    maze_state <= r_target;
                end
                if (r_state == S_CHECK && w_state_nxt == S_MOVING) begin
                    r_count <= c_load;
                    dir     <= w_adj_dir;
                end else if (r_state == S_MOVING && r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
